// File: rtl/aes_axil_pkg.sv
// Shared definitions for the AES AXI4-Lite register bank: register offsets,
// CTRL/STATUS bit positions, the latency counter width and the sequencer
// state type. Used by aes_axil_slave_if and aes_axil_regbank.
package aes_axil_pkg;

    localparam int OFS_CTRL      = 'h00;
    localparam int OFS_STATUS    = 'h04;
    localparam int OFS_CYCLES    = 'h08;
    localparam int OFS_KEY0      = 'h10;
    localparam int OFS_DIN0      = 'h30;
    localparam int OFS_DOUT0     = 'h40;
    localparam int MAX_KEY_WORDS = 8;

    localparam int CTRL_START    = 0;
    localparam int CTRL_MODE     = 1;
    localparam int CTRL_IRQ_EN   = 2;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_DONE     = 1;
    localparam int STAT_ERR      = 2;

    localparam int CYCLES_W      = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Merge a bus write into a 32-bit register one byte lane at a time.
    function automatic logic [31:0] apply_strb(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_axil_slave_if.sv
// AXI4-Lite handshake front end. Turns the five AXI channels into a one-cycle
// write strobe (wr_en/wr_addr/wr_data/wr_strb) and a read request
// (rd_en/rd_addr) whose combinational rd_data answer is registered onto RDATA.
// Responses are always OKAY.
module aes_axil_slave_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [ADDR_W-1:0]   aw_addr,
    input  logic                aw_valid,
    output logic                aw_ready,
    input  logic [DATA_W-1:0]   w_data,
    input  logic [DATA_W/8-1:0] w_strb,
    input  logic                w_valid,
    output logic                w_ready,
    output logic [1:0]          b_resp,
    output logic                b_valid,
    input  logic                b_ready,
    input  logic [ADDR_W-1:0]   ar_addr,
    input  logic                ar_valid,
    output logic                ar_ready,
    output logic [DATA_W-1:0]   r_data,
    output logic [1:0]          r_resp,
    output logic                r_valid,
    input  logic                r_ready,
    output logic                wr_en,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W/8-1:0] wr_strb,
    output logic                rd_en,
    output logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   rd_data
);

    assign wr_en   = aw_ready & aw_valid & w_valid;
    assign wr_addr = aw_addr;
    assign wr_data = w_data;
    assign wr_strb = w_strb;
    assign rd_en   = ar_ready & ar_valid;
    assign rd_addr = ar_addr;
    assign b_resp  = 2'b00;
    assign r_resp  = 2'b00;

    // Write path: one-cycle AW/W ready pulse, then hold BVALID until BREADY.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_ready <= 1'b0;
            w_ready  <= 1'b0;
            b_valid  <= 1'b0;
        end else begin
            aw_ready <= aw_valid && w_valid && !b_valid && !aw_ready;
            w_ready  <= aw_valid && w_valid && !b_valid && !aw_ready;
            if (wr_en) begin
                b_valid <= 1'b1;
            end else if (b_valid && b_ready) begin
                b_valid <= 1'b0;
            end
        end
    end

    // Read path: one-cycle ARREADY pulse, capture the data, hold RVALID until RREADY.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ar_ready <= 1'b0;
            r_valid  <= 1'b0;
            r_data   <= '0;
        end else begin
            ar_ready <= ar_valid && !r_valid && !ar_ready;
            if (rd_en) begin
                r_valid <= 1'b1;
                r_data  <= rd_data;
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/aes_axil_regbank.sv
// AXI4-Lite register bank and two-state sequencer in front of a fixed-latency
// AES core: key/input/output block registers, CTRL/STATUS with a
// start/busy/done handshake, and a saturating latency counter.
// Optional level interrupt enabled by defining AES_REGS_IRQ_EN.
module aes_axil_regbank
    import aes_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 7,
    parameter int NUM_KEY_WORDS      = 4,
    parameter int NUM_BLK_WORDS      = 4
) (
    input  logic                            s00_axi_aclk,
    input  logic                            s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
    input  logic [2:0]                      s00_axi_awprot,
    input  logic                            s00_axi_awvalid,
    output logic                            s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
    input  logic                            s00_axi_wvalid,
    output logic                            s00_axi_wready,
    output logic [1:0]                      s00_axi_bresp,
    output logic                            s00_axi_bvalid,
    input  logic                            s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
    input  logic [2:0]                      s00_axi_arprot,
    input  logic                            s00_axi_arvalid,
    output logic                            s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
    output logic [1:0]                      s00_axi_rresp,
    output logic                            s00_axi_rvalid,
    input  logic                            s00_axi_rready,
    output logic                            core_start,
    output logic                            core_mode,
    output logic [32*NUM_KEY_WORDS-1:0]     core_key,
    output logic [32*NUM_BLK_WORDS-1:0]     core_din,
    input  logic                            core_done,
    input  logic [32*NUM_BLK_WORDS-1:0]     core_dout
`ifdef AES_REGS_IRQ_EN
    ,
    output logic                            irq
`endif
);

    logic                            wr_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   wr_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic                            rd_en;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   rd_addr;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rd_data;

    state_t                state;
    logic                  busy;
    logic                  mode_q;
    logic                  irq_en_q;
    logic                  done_q;
    logic                  err_q;
    logic                  core_start_q;
    logic [CYCLES_W-1:0]   cycles_q;
    logic [31:0]           key_q  [NUM_KEY_WORDS];
    logic [31:0]           din_q  [NUM_BLK_WORDS];
    logic [31:0]           dout_q [NUM_BLK_WORDS];

    int                    wr_word;
    int                    rd_word;
    logic                  wr_ctrl;
    logic                  wr_status;
    logic                  start_req;
    logic                  clr_done;
    logic                  clr_err;
    logic                  unused_ok;

    aes_axil_slave_if #(
        .DATA_W (C_S_AXI_DATA_WIDTH),
        .ADDR_W (C_S_AXI_ADDR_WIDTH)
    ) u_slave (
        .clk      (s00_axi_aclk),
        .resetn   (s00_axi_aresetn),
        .aw_addr  (s00_axi_awaddr),
        .aw_valid (s00_axi_awvalid),
        .aw_ready (s00_axi_awready),
        .w_data   (s00_axi_wdata),
        .w_strb   (s00_axi_wstrb),
        .w_valid  (s00_axi_wvalid),
        .w_ready  (s00_axi_wready),
        .b_resp   (s00_axi_bresp),
        .b_valid  (s00_axi_bvalid),
        .b_ready  (s00_axi_bready),
        .ar_addr  (s00_axi_araddr),
        .ar_valid (s00_axi_arvalid),
        .ar_ready (s00_axi_arready),
        .r_data   (s00_axi_rdata),
        .r_resp   (s00_axi_rresp),
        .r_valid  (s00_axi_rvalid),
        .r_ready  (s00_axi_rready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_strb  (wr_strb),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    assign busy       = (state == RUN);
    assign core_start = core_start_q;
    assign core_mode  = mode_q;
    assign unused_ok  = ^{s00_axi_awprot, s00_axi_arprot, wr_addr[1:0], rd_addr[1:0]};

`ifdef AES_REGS_IRQ_EN
    assign irq = done_q & irq_en_q;
`else
    assign irq_en_q = 1'b0;
`endif

    // Decode the write strobe into per-register actions on CTRL and STATUS.
    always_comb begin
        wr_word   = int'(wr_addr[C_S_AXI_ADDR_WIDTH-1:2]);
        wr_ctrl   = wr_en && (wr_word == OFS_CTRL / 4);
        wr_status = wr_en && (wr_word == OFS_STATUS / 4);
        start_req = wr_ctrl && wr_strb[0] && wr_data[CTRL_START];
        clr_done  = wr_status && wr_strb[0] && wr_data[STAT_DONE];
        clr_err   = wr_status && wr_strb[0] && wr_data[STAT_ERR];
    end

    // Flatten the key and input block words onto the core buses, word 0 lowest.
    always_comb begin
        for (int i = 0; i < NUM_KEY_WORDS; i++) core_key[32*i +: 32] = key_q[i];
        for (int i = 0; i < NUM_BLK_WORDS; i++) core_din[32*i +: 32] = din_q[i];
    end

    // CTRL mode and interrupt enable; mode is frozen while an operation runs.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            mode_q <= 1'b0;
`ifdef AES_REGS_IRQ_EN
            irq_en_q <= 1'b0;
`endif
        end else if (wr_ctrl && wr_strb[0]) begin
            if (!busy) mode_q <= wr_data[CTRL_MODE];
`ifdef AES_REGS_IRQ_EN
            irq_en_q <= wr_data[CTRL_IRQ_EN];
`endif
        end
    end

    // Key and input block registers, byte-strobed and locked while busy.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            for (int i = 0; i < NUM_KEY_WORDS; i++) key_q[i] <= '0;
            for (int i = 0; i < NUM_BLK_WORDS; i++) din_q[i] <= '0;
        end else if (wr_en && !busy) begin
            for (int i = 0; i < NUM_KEY_WORDS; i++) begin
                if (wr_word == OFS_KEY0 / 4 + i) key_q[i] <= apply_strb(key_q[i], wr_data, wr_strb);
            end
            for (int i = 0; i < NUM_BLK_WORDS; i++) begin
                if (wr_word == OFS_DIN0 / 4 + i) din_q[i] <= apply_strb(din_q[i], wr_data, wr_strb);
            end
        end
    end

    // Sequencer: launch on START, time the core, capture the result on done,
    // and maintain the sticky DONE/ERR flags (a set beats a same-cycle clear).
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            state        <= IDLE;
            core_start_q <= 1'b0;
            cycles_q     <= '0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_BLK_WORDS; i++) dout_q[i] <= '0;
        end else begin
            core_start_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        state        <= RUN;
                        core_start_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (core_start_q) begin
                        cycles_q <= '0;
                    end else if (cycles_q != '1) begin
                        cycles_q <= cycles_q + 1'b1;
                    end
                    if (core_done) begin
                        state <= IDLE;
                        for (int i = 0; i < NUM_BLK_WORDS; i++) dout_q[i] <= core_dout[32*i +: 32];
                    end
                end
                default: state <= IDLE;
            endcase

            if (busy && core_done) begin
                done_q <= 1'b1;
            end else if (clr_done) begin
                done_q <= 1'b0;
            end

            if (busy && start_req) begin
                err_q <= 1'b1;
            end else if (clr_err) begin
                err_q <= 1'b0;
            end
        end
    end

    // Read mux; anything outside the implemented map returns zero.
    always_comb begin
        rd_data = '0;
        rd_word = int'(rd_addr[C_S_AXI_ADDR_WIDTH-1:2]);
        if (rd_en) begin
            if (rd_word == OFS_CTRL / 4) begin
                rd_data[CTRL_MODE]   = mode_q;
                rd_data[CTRL_IRQ_EN] = irq_en_q;
            end
            if (rd_word == OFS_STATUS / 4) begin
                rd_data[STAT_BUSY] = busy;
                rd_data[STAT_DONE] = done_q;
                rd_data[STAT_ERR]  = err_q;
            end
            if (rd_word == OFS_CYCLES / 4) begin
                rd_data[CYCLES_W-1:0] = cycles_q;
            end
            for (int i = 0; i < NUM_KEY_WORDS; i++) begin
                if (rd_word == OFS_KEY0 / 4 + i) rd_data = key_q[i];
            end
            for (int i = 0; i < NUM_BLK_WORDS; i++) begin
                if (rd_word == OFS_DIN0 / 4 + i)  rd_data = din_q[i];
                if (rd_word == OFS_DOUT0 / 4 + i) rd_data = dout_q[i];
            end
        end
    end

endmodule

// File: tb/tb_aes_axil_regbank.sv
// Directed self-checking bench for aes_axil_regbank. A small core stub answers
// core_start with core_done after a programmable latency and returns the
// FIPS-197 appendix ciphertext only when the expected key/block were presented.
// Interrupt checks are compiled in when AES_REGS_IRQ_EN is defined.
module tb_aes_axil_regbank;

    localparam logic [31:0] KEY_W [4] = '{32'h2B7E1516, 32'h28AED2A6, 32'hABF71588, 32'h09CF4F3C};
    localparam logic [31:0] DIN_W [4] = '{32'h3243F6A8, 32'h885A308D, 32'h313198A2, 32'hE0370734};
    localparam logic [31:0] CT_W  [4] = '{32'h3925841D, 32'h02DC09FB, 32'hDC118597, 32'h196A0B32};

    logic         clk = 1'b0;
    logic         aresetn = 1'b0;
    logic [6:0]   awaddr = '0;
    logic         awvalid = 1'b0;
    logic         awready;
    logic [31:0]  wdata = '0;
    logic [3:0]   wstrb = '0;
    logic         wvalid = 1'b0;
    logic         wready;
    logic [1:0]   bresp;
    logic         bvalid;
    logic         bready = 1'b0;
    logic [6:0]   araddr = '0;
    logic         arvalid = 1'b0;
    logic         arready;
    logic [31:0]  rdata;
    logic [1:0]   rresp;
    logic         rvalid;
    logic         rready = 1'b0;
    logic         core_start;
    logic         core_mode;
    logic [127:0] core_key;
    logic [127:0] core_din;
    logic         core_done;
    logic [127:0] core_dout;
`ifdef AES_REGS_IRQ_EN
    logic         irq;
`endif

    int   total = 0;
    int   bad = 0;
    int   lat = 41;
    bit   stub_auto = 1'b1;
    bit   manual_done = 1'b0;
    bit   running = 1'b0;
    bit   key_ok = 1'b0;
    int   cnt = 0;
    int   start_cnt = 0;
    time  hs_time = 0;
    time  start_time = 0;

    always #5 clk = ~clk;

    aes_axil_regbank dut (
        .s00_axi_aclk    (clk),
        .s00_axi_aresetn (aresetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (3'b000),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (3'b000),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .core_start      (core_start),
        .core_mode       (core_mode),
        .core_key        (core_key),
        .core_din        (core_din),
        .core_done       (core_done),
        .core_dout       (core_dout)
`ifdef AES_REGS_IRQ_EN
        ,
        .irq             (irq)
`endif
    );

    // Core stub sharing the bus reset: done pulses lat cycles after core_start.
    always @(posedge clk) begin
        if (!aresetn) begin
            running <= 1'b0;
            cnt     <= 0;
        end else if (core_start && stub_auto) begin
            running <= 1'b1;
            cnt     <= 1;
            key_ok  <= (core_key == {KEY_W[3], KEY_W[2], KEY_W[1], KEY_W[0]}) &&
                       (core_din == {DIN_W[3], DIN_W[2], DIN_W[1], DIN_W[0]}) && !core_mode;
        end else if (running) begin
            if (cnt == lat) running <= 1'b0;
            else cnt <= cnt + 1;
        end
    end

    assign core_done = (running && cnt == lat) || manual_done;
    assign core_dout = key_ok ? {CT_W[3], CT_W[2], CT_W[1], CT_W[0]} : {4{32'hDEADBEEF}};

    // Event monitor: time of last write handshake, count and time of start pulses.
    always @(posedge clk) begin
        if (awready && awvalid && wvalid) hs_time <= $time;
        if (core_start) begin
            start_cnt  <= start_cnt + 1;
            start_time <= $time;
        end
    end

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d, input logic [3:0] s, input bit inj);
        bit ok;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("[TB] FAIL aw_timeout addr=%h: awready=0 required 1", a); end
        if (inj) manual_done = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; manual_done = 1'b0;
        bready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bvalid) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("[TB] FAIL b_timeout addr=%h: bvalid=0 required 1", a); end
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] r);
        bit ok;
        araddr = a; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("[TB] FAIL ar_timeout addr=%h: arready=0 required 1", a); end
        @(posedge clk); #1;
        arvalid = 1'b0;
        rready = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rvalid) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("[TB] FAIL r_timeout addr=%h: rvalid=0 required 1", a); end
        d = rdata; r = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (core_done) begin ok = 1'b1; break; end
        end
        if (!ok) begin total++; bad++; $display("[TB] FAIL done_timeout: core_done=0 required 1"); end
        @(posedge clk); #1;
    endtask

    task automatic load_vectors();
        for (int i = 0; i < 4; i++) axi_write(7'(16 + 4*i), KEY_W[i], 4'hF, 1'b0);
        for (int i = 0; i < 4; i++) axi_write(7'(48 + 4*i), DIN_W[i], 4'hF, 1'b0);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic [6:0]  addrs [6];
        addrs = '{7'h00, 7'h04, 7'h08, 7'h10, 7'h3C, 7'h40};
        aresetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({awready, wready, bvalid, arready, rvalid, bresp, rresp} !== 9'b0) begin
            bad++; $display("[TB] FAIL reset_axi: got %b required 0", {awready, wready, bvalid, arready, rvalid, bresp, rresp});
        end
        total++;
        if ({core_start, core_mode, core_key, core_din} !== '0) begin
            bad++; $display("[TB] FAIL reset_core: start=%b mode=%b key=%h din=%h required all 0", core_start, core_mode, core_key, core_din);
        end
`ifdef AES_REGS_IRQ_EN
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq: got %b required 0", irq); end
`endif
        @(posedge clk); #1;
        aresetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            axi_read(addrs[i], d, r);
            total++;
            if (d !== 32'h0) begin bad++; $display("[TB] FAIL reset_read addr=%h: got %h required 0", addrs[i], d); end
        end
    endtask

    task automatic test_strobe_map();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(7'h10, 32'h2B7E1516, 4'h3, 1'b0);
        axi_read(7'h10, d, r);
        total++;
        if (d !== 32'h00001516) begin bad++; $display("[TB] FAIL key0_strb3: got %h required 00001516", d); end
        axi_write(7'h10, 32'h2B7E1516, 4'hC, 1'b0);
        axi_read(7'h10, d, r);
        total++;
        if (d !== 32'h2B7E1516) begin bad++; $display("[TB] FAIL key0_strbC: got %h required 2B7E1516", d); end
        axi_write(7'h28, 32'hFFFFFFFF, 4'hF, 1'b0);
        axi_read(7'h28, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL key6_absent: got %h required 0", d); end
        axi_write(7'h0C, 32'hFFFFFFFF, 4'hF, 1'b0);
        axi_read(7'h0C, d, r);
        total++;
        if ({d, r} !== 34'h0) begin bad++; $display("[TB] FAIL unmapped_0C: got %h resp %b required 0 OKAY", d, r); end
        axi_read(7'h50, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL unmapped_50: got %h required 0", d); end
    endtask

    task automatic test_encrypt();
        logic [31:0] d;
        logic [1:0]  r;
        int          c0;
        stub_auto = 1'b1; lat = 41;
        load_vectors();
        total++;
        if (core_key !== {KEY_W[3], KEY_W[2], KEY_W[1], KEY_W[0]}) begin
            bad++; $display("[TB] FAIL core_key: got %h required %h", core_key, {KEY_W[3], KEY_W[2], KEY_W[1], KEY_W[0]});
        end
        total++;
        if (core_din !== {DIN_W[3], DIN_W[2], DIN_W[1], DIN_W[0]}) begin
            bad++; $display("[TB] FAIL core_din: got %h required %h", core_din, {DIN_W[3], DIN_W[2], DIN_W[1], DIN_W[0]});
        end
        c0 = start_cnt;
        axi_write(7'h00, 32'h1, 4'hF, 1'b0);
        total++;
        if (start_time - hs_time != 10) begin bad++; $display("[TB] FAIL start_latency: got %0t required 10", start_time - hs_time); end
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h1) begin bad++; $display("[TB] FAIL status_busy: got %h required 00000001", d); end
        wait_done();
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL status_done: got %h required 00000002", d); end
        axi_read(7'h08, d, r);
        total++;
        if (d !== 32'd41) begin bad++; $display("[TB] FAIL cycles: got %0d required 41", d); end
        for (int i = 0; i < 4; i++) begin
            axi_read(7'(64 + 4*i), d, r);
            total++;
            if (d !== CT_W[i]) begin bad++; $display("[TB] FAIL dout%0d: got %h required %h", i, d, CT_W[i]); end
        end
        total++;
        if (start_cnt - c0 != 1) begin bad++; $display("[TB] FAIL start_count: got %0d required 1", start_cnt - c0); end
    endtask

    task automatic test_busy_err();
        logic [31:0] d;
        logic [1:0]  r;
        int          c0;
        c0 = start_cnt;
        axi_write(7'h00, 32'h1, 4'hF, 1'b0);
        axi_write(7'h00, 32'h3, 4'hF, 1'b0);
        axi_write(7'h30, 32'hFFFFFFFF, 4'hF, 1'b0);
        axi_write(7'h14, 32'h0, 4'hF, 1'b0);
        total++;
        if (core_mode !== 1'b0) begin bad++; $display("[TB] FAIL mode_locked: got %b required 0", core_mode); end
        wait_done();
        total++;
        if (start_cnt - c0 != 1) begin bad++; $display("[TB] FAIL busy_start_count: got %0d required 1", start_cnt - c0); end
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h6) begin bad++; $display("[TB] FAIL status_err: got %h required 00000006", d); end
        axi_read(7'h30, d, r);
        total++;
        if (d !== DIN_W[0]) begin bad++; $display("[TB] FAIL din_locked: got %h required %h", d, DIN_W[0]); end
        axi_read(7'h40, d, r);
        total++;
        if (d !== CT_W[0]) begin bad++; $display("[TB] FAIL dout_after_err: got %h required %h", d, CT_W[0]); end
        axi_write(7'h04, 32'h6, 4'hF, 1'b0);
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL status_w1c: got %h required 0", d); end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] d;
        logic [1:0]  r;
        stub_auto = 1'b0;
        axi_write(7'h00, 32'h1, 4'hF, 1'b0);
        repeat (8) @(posedge clk);
        #1 aresetn = 1'b0;
        @(posedge clk); #1;
        total++;
        if ({core_start, core_mode, core_key, core_din, bvalid, rvalid} !== '0) begin
            bad++; $display("[TB] FAIL midrun_reset_outputs: start=%b key=%h din=%h required 0", core_start, core_key, core_din);
        end
        aresetn = 1'b1;
        @(posedge clk); #1 manual_done = 1'b1;
        @(posedge clk); #1 manual_done = 1'b0;
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL late_done_status: got %h required 0", d); end
        axi_read(7'h40, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL late_done_dout: got %h required 0", d); end
    endtask

    task automatic test_done_race();
        logic [31:0] d;
        logic [1:0]  r;
        load_vectors();
        stub_auto = 1'b1;
        axi_write(7'h00, 32'h5, 4'hF, 1'b0);
        wait_done();
        axi_read(7'h00, d, r);
        total++;
`ifdef AES_REGS_IRQ_EN
        if (d !== 32'h4) begin bad++; $display("[TB] FAIL ctrl_read: got %h required 00000004", d); end
        total++;
        if (irq !== 1'b1) begin bad++; $display("[TB] FAIL irq_set: got %b required 1", irq); end
`else
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL ctrl_read: got %h required 0", d); end
`endif
        stub_auto = 1'b0;
        axi_write(7'h00, 32'h5, 4'hF, 1'b0);
        axi_write(7'h04, 32'h2, 4'hF, 1'b1);
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h2) begin bad++; $display("[TB] FAIL done_set_wins: got %h required 00000002", d); end
        axi_write(7'h04, 32'h2, 4'hF, 1'b0);
`ifdef AES_REGS_IRQ_EN
        total++;
        if (irq !== 1'b0) begin bad++; $display("[TB] FAIL irq_clear: got %b required 0", irq); end
`endif
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h0) begin bad++; $display("[TB] FAIL done_cleared: got %h required 0", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int          drop;
        int          acc;
        int          wrong;
        bit          ok;
        awaddr = 7'h34; wdata = 32'hAAAA5555; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL bp_aw1: awready=0 required 1"); end
        @(posedge clk); #1;
        awaddr = 7'h38; wdata = 32'h12345678;
        drop = 0; acc = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bvalid) drop++;
            if (awready) acc++;
        end
        total++;
        if (drop != 0) begin bad++; $display("[TB] FAIL bvalid_hold: dropped %0d cycles required 0", drop); end
        total++;
        if (acc != 0) begin bad++; $display("[TB] FAIL second_write_blocked: accepted %0d required 0", acc); end
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL bp_aw2: awready=0 required 1"); end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;

        araddr = 7'h34; arvalid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; break; end
        end
        total++;
        if (!ok) begin bad++; $display("[TB] FAIL bp_ar1: arready=0 required 1"); end
        @(posedge clk); #1;
        araddr = 7'h38;
        drop = 0; acc = 0; wrong = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!rvalid) drop++;
            if (arready) acc++;
            if (rdata !== 32'hAAAA5555) wrong++;
        end
        total++;
        if (drop != 0) begin bad++; $display("[TB] FAIL rvalid_hold: dropped %0d cycles required 0", drop); end
        total++;
        if (acc != 0) begin bad++; $display("[TB] FAIL second_read_blocked: accepted %0d required 0", acc); end
        total++;
        if (wrong != 0) begin bad++; $display("[TB] FAIL din1_read: rdata=%h required AAAA5555", rdata); end
        rready = 1'b1;
        @(posedge clk); #1 rready = 1'b0;
        arvalid = 1'b0;
        axi_read(7'h38, d, r);
        total++;
        if (d !== 32'h12345678) begin bad++; $display("[TB] FAIL din2_read: got %h required 12345678", d); end
        axi_read(7'h0C, d, r);
        total++;
        if ({d, r} !== 34'h0) begin bad++; $display("[TB] FAIL unmapped_read: got %h resp %b required 0 OKAY", d, r); end
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_strobe_map();
        test_encrypt();
        test_busy_err();
        test_reset_midrun();
        test_done_race();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
